// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, talks to a
// variable-latency instruction memory, and honours hazard freezes and EXE redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_ID,
    output logic [31:0] instruction_ID,
    output logic        valid_ID
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] w_pcNext;
    logic [31:0] r_holdBuf;
    logic [31:0] w_holdBufNext;
    logic [31:0] r_redirect;
    logic [31:0] w_redirectNext;
    logic [31:0] r_instrId;
    logic [31:0] w_instrIdNext;
    logic [31:0] r_pcId;
    logic [31:0] w_pcIdNext;
    logic        r_validId;
    logic        w_validIdNext;
    logic [31:0] w_pcPlus4;

    assign w_pcPlus4 = r_pc + 32'd4;

    // The request is gated by reset so an abandoned transfer drops immediately.
    assign imem_req       = rst & (r_state != HOLD);
    assign imem_addr      = r_pc;
    assign PC_ID          = r_pcId;
    assign instruction_ID = r_instrId;
    assign valid_ID       = r_validId;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_holdBuf  <= 32'd0;
            r_redirect <= 32'd0;
            r_instrId  <= 32'd0;
            r_pcId     <= 32'd0;
            r_validId  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_holdBuf  <= w_holdBufNext;
            r_redirect <= w_redirectNext;
            r_instrId  <= w_instrIdNext;
            r_pcId     <= w_pcIdNext;
            r_validId  <= w_validIdNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_holdBufNext  = r_holdBuf;
        w_redirectNext = r_redirect;
        w_instrIdNext  = r_instrId;
        w_pcIdNext     = r_pcId;
        w_validIdNext  = r_validId;

        case (r_state)
            FETCH: begin
                // A redirect with an outstanding request must keep the address stable until ack.
                if (branch_taken) begin
                    w_validIdNext = 1'b0;
                    if (imem_ack) begin
                        w_pcNext = branch_addr;
                    end else begin
                        w_redirectNext = branch_addr;
                        w_stateNext    = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (hazard) begin
                        w_holdBufNext = imem_rdata;
                        w_stateNext   = HOLD;
                    end else begin
                        w_instrIdNext = imem_rdata;
                        w_pcIdNext    = w_pcPlus4;
                        w_validIdNext = 1'b1;
                        w_pcNext      = w_pcPlus4;
                    end
                end else if (!hazard) begin
                    w_validIdNext = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_validIdNext = 1'b0;
                    w_pcNext      = branch_addr;
                    w_stateNext   = FETCH;
                end else if (!hazard) begin
                    w_instrIdNext = r_holdBuf;
                    w_pcIdNext    = w_pcPlus4;
                    w_validIdNext = 1'b1;
                    w_pcNext      = w_pcPlus4;
                    w_stateNext   = FETCH;
                end
            end
            DRAIN: begin
                w_validIdNext = 1'b0;
                if (branch_taken) begin
                    w_redirectNext = branch_addr;
                end
                if (imem_ack) begin
                    w_pcNext    = branch_taken ? branch_addr : r_redirect;
                    w_stateNext = FETCH;
                end
            end
            default: begin
                w_stateNext = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed test-plan sequences followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] instruction_ID;
    logic        valid_ID;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .PC_ID         (PC_ID),
        .instruction_ID(instruction_ID),
        .valid_ID      (valid_ID)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pcId;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;

    // Reference model: the address being requested, an optional parked word,
    // an optional pending redirect target, and what ID currently sees.
    logic [31:0] mPc;
    logic        mParked;
    logic [31:0] mParkedWord;
    logic        mPending;
    logic [31:0] mTarget;
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mPcId;

    function automatic void modelReset();
        mPc = 32'h0; mParked = 1'b0; mParkedWord = 32'h0;
        mPending = 1'b0; mTarget = 32'h0;
        mValid = 1'b0; mInstr = 32'h0; mPcId = 32'h0;
    endfunction

    function automatic void modelStep(input logic hz, input logic br, input logic [31:0] ba,
                                      input logic ack, input logic [31:0] rd);
        logic        req;
        logic        done;
        logic        avail;
        logic [31:0] word;
        req  = !mParked;
        done = req && ack;
        if (mPending) begin
            if (br) mTarget = ba;
            mValid = 1'b0;
            if (done) begin
                mPc      = mTarget;
                mPending = 1'b0;
            end
        end else if (br) begin
            mValid  = 1'b0;
            mParked = 1'b0;
            if (req && !done) begin
                mPending = 1'b1;
                mTarget  = ba;
            end else begin
                mPc = ba;
            end
        end else begin
            avail = mParked || done;
            word  = mParked ? mParkedWord : rd;
            if (avail && !hz) begin
                mInstr  = word;
                mPcId   = mPc + 32'd4;
                mValid  = 1'b1;
                mPc     = mPc + 32'd4;
                mParked = 1'b0;
            end else if (avail) begin
                mParked     = 1'b1;
                mParkedWord = word;
            end else if (!hz) begin
                mValid = 1'b0;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, record what the DUT should show this cycle, advance the model.
    task automatic applyStimulus(input logic hz, input logic br, input logic [31:0] ba, input logic ack);
        exp_t        e;
        logic [31:0] rd;
        @(negedge clk);
        rd           = mPc ^ 32'hE000_0000;
        hazard       = hz;
        branch_taken = br;
        branch_addr  = ba;
        imem_ack     = ack;
        imem_rdata   = rd;
        e.req   = !mParked;
        e.addr  = mPc;
        e.valid = mValid;
        e.instr = mInstr;
        e.pcId  = mPcId;
        expQ.push_back(e);
        modelStep(hz, br, ba, ack, rd);
    endtask

    task automatic idleInputs();
        hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        checkOutput({tag, "_addr"},  imem_addr,         32'd0);
        checkOutput({tag, "_valid"}, {31'd0, valid_ID}, 32'd0);
        checkOutput({tag, "_instr"}, instruction_ID,    32'd0);
        checkOutput({tag, "_pcid"},  PC_ID,             32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("imem_req",       {31'd0, imem_req}, {31'd0, e.req});
                checkOutput("imem_addr",      imem_addr,         e.addr);
                checkOutput("valid_ID",       {31'd0, valid_ID}, {31'd0, e.valid});
                if (e.valid) begin
                    checkOutput("instruction_ID", instruction_ID, e.instr);
                    checkOutput("PC_ID",          PC_ID,          e.pcId);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0;
        idleInputs();
        modelReset();
        #3;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait fetch of 0 and 4
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Hazard for three cycles starting at the fetch of 8, then continue
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Branch with no pending request
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Branch into a pending request at 0x10: targets 200 then 300, latest wins
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Branch beats hazard while a word is parked
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Wrap through the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        // Async reset in the middle of a stalled transfer
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset_held");
        idleInputs();
        modelReset();
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom,
                          $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        #3;
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
